dcm_lock_seq: RTL and testbench

DCM_LOCK_SEQ -- requirements
Module: dcm_lock_seq

---
 rtl/dcm_seq_pkg.sv | 12 +
 rtl/sync_2ff.sv | 13 +
 rtl/dcm_lock_seq.sv | 108 ++++++++++
 tb/tb_dcm_lock_seq.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/dcm_seq_pkg.sv
// dcm_seq_pkg: shared state encoding and DCM STATUS bit indices for the DCM lock sequencer
package dcm_seq_pkg;
  typedef enum logic [2:0] {
    RESET_DCM = 3'd0,
    WAIT_LOCK = 3'd1,
    SETTLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;
  localparam int STAT_CLKIN_STOP = 1;
  localparam int STAT_CLKFX_STOP = 2;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous flag
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;
  // first flop absorbs metastability, second presents a clean level
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, meta} <= 2'b00;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/dcm_lock_seq.sv
// dcm_lock_seq: DCM reset/lock sequencer with retry and fault handling; define DCM_STATUS_MON_EN to treat CLKIN/CLKFX-stopped status as lock loss
module dcm_lock_seq
  import dcm_seq_pkg::*;
#(
  parameter int RST_PULSE_CYCLES = 3,
  parameter int LOCK_TIMEOUT     = 500000,
  parameter int SETTLE_CYCLES    = 16,
  parameter int MAX_RETRY        = 7,
  localparam int RW = $clog2(MAX_RETRY + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          DCM_LOCKED,
  input  logic [7:0]    DCM_STATUS,
  input  logic          REQ_RELOCK,
  output logic          DCM_RST,
  output logic          SYS_RST,
  output logic          READY,
  output logic          FAIL,
  output logic [RW-1:0] RETRY_CNT
);
  localparam int TA   = LOCK_TIMEOUT > SETTLE_CYCLES ? LOCK_TIMEOUT : SETTLE_CYCLES;
  localparam int TMAX = TA > RST_PULSE_CYCLES ? TA : RST_PULSE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  state_t          st, nxt;
  logic [TW-1:0]   t, t_nxt, t_inc;
  logic [RW-1:0]   r_nxt;
  logic            f_nxt, lock_s, stat_bad, unused_status;
  sync_2ff u_sync (.clk(CLK), .rst(RST), .d(DCM_LOCKED), .q(lock_s));
`ifdef DCM_STATUS_MON_EN
  assign stat_bad = DCM_STATUS[STAT_CLKIN_STOP] | DCM_STATUS[STAT_CLKFX_STOP];
`else
  assign stat_bad = 1'b0;
`endif
  assign unused_status = ^DCM_STATUS;
  assign t_inc = (t == '1) ? t : t + 1'b1;
  // next state, shared phase timer, retry count and fault flag
  always_comb begin
    nxt   = st;
    t_nxt = t_inc;
    r_nxt = RETRY_CNT;
    f_nxt = FAIL;
    if (REQ_RELOCK) begin
      nxt   = RESET_DCM;
      t_nxt = '0;
      r_nxt = '0;
      f_nxt = 1'b0;
    end else begin
      case (st)
        RESET_DCM:
          if (t == TW'(RST_PULSE_CYCLES - 1)) begin
            nxt   = WAIT_LOCK;
            t_nxt = '0;
          end
        WAIT_LOCK:
          if (lock_s) begin
            nxt   = SETTLE;
            t_nxt = '0;
          end else if (t == TW'(LOCK_TIMEOUT - 1)) begin
            t_nxt = '0;
            nxt   = (RETRY_CNT == RW'(MAX_RETRY)) ? FAULT : RESET_DCM;
            f_nxt = (RETRY_CNT == RW'(MAX_RETRY));
            r_nxt = (RETRY_CNT == RW'(MAX_RETRY)) ? RETRY_CNT : RETRY_CNT + 1'b1;
          end
        SETTLE:
          if (stat_bad) begin
            nxt   = RESET_DCM;
            t_nxt = '0;
          end else if (!lock_s) begin
            nxt   = WAIT_LOCK;
            t_nxt = '0;
          end else if (t == TW'(SETTLE_CYCLES - 1)) begin
            nxt   = RUN;
            t_nxt = '0;
          end
        RUN:
          if (!lock_s || stat_bad) begin
            nxt   = RESET_DCM;
            t_nxt = '0;
          end
        FAULT:   t_nxt = t;
        default: begin
          nxt   = RESET_DCM;
          t_nxt = '0;
        end
      endcase
    end
  end
  // state, timer and registered outputs decoded from the next state
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      st        <= RESET_DCM;
      t         <= '0;
      RETRY_CNT <= '0;
      FAIL      <= 1'b0;
      DCM_RST   <= 1'b1;
      SYS_RST   <= 1'b1;
      READY     <= 1'b0;
    end else begin
      st        <= nxt;
      t         <= t_nxt;
      RETRY_CNT <= r_nxt;
      FAIL      <= f_nxt;
      DCM_RST   <= (nxt == RESET_DCM);
      SYS_RST   <= (nxt != RUN);
      READY     <= (nxt == RUN);
    end
endmodule

// File: tb/tb_dcm_lock_seq.sv
// tb_dcm_lock_seq: directed and randomized checks of dcm_lock_seq against a phase/elapsed-time reference model
module tb_dcm_lock_seq;
  localparam int RP = 3, LT = 20, SC = 4, MR = 2;
  logic       clk = 0, rst = 1, dcm_locked = 0, req = 0;
  logic [7:0] dcm_status = 0;
  logic       dcm_rst, sys_rst, ready, fail;
  logic [1:0] retry_cnt;
  int n_chk = 0, n_fail = 0;
  int cyc = 0, entry = 0, retries = 0;
  bit failed = 0;
  bit lq[$];
  typedef enum {P_RESET, P_WAIT, P_SETTLE, P_RUN, P_FAULT} phase_t;
  phase_t ph = P_RESET;

  dcm_lock_seq #(.RST_PULSE_CYCLES(RP), .LOCK_TIMEOUT(LT), .SETTLE_CYCLES(SC), .MAX_RETRY(MR)) dut (
    .CLK(clk), .RST(rst), .DCM_LOCKED(dcm_locked), .DCM_STATUS(dcm_status), .REQ_RELOCK(req),
    .DCM_RST(dcm_rst), .SYS_RST(sys_rst), .READY(ready), .FAIL(fail), .RETRY_CNT(retry_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // reference: lock seen by decisions is the input sampled two edges earlier;
  // each phase is timed by edges elapsed since it was entered
  task automatic model_edge();
    bit ls, bad;
    int el;
    phase_t nph;
    if (rst) begin
      ph = P_RESET; entry = cyc + 1; retries = 0; failed = 0;
      lq.delete(); lq.push_back(1'b0); lq.push_back(1'b0);
      return;
    end
    ls = lq.pop_front();
    lq.push_back(dcm_locked);
    el = cyc - entry;
`ifdef DCM_STATUS_MON_EN
    bad = dcm_status[1] | dcm_status[2];
`else
    bad = 0;
`endif
    nph = ph;
    if (req) begin
      nph = P_RESET; retries = 0; failed = 0;
    end else if (ph == P_RESET) begin
      if (el == RP - 1) nph = P_WAIT;
    end else if (ph == P_WAIT) begin
      if (ls) nph = P_SETTLE;
      else if (el == LT - 1) begin
        if (retries == MR) begin nph = P_FAULT; failed = 1; end
        else begin retries++; nph = P_RESET; end
      end
    end else if (ph == P_SETTLE) begin
      nph = bad ? P_RESET : !ls ? P_WAIT : (el == SC - 1) ? P_RUN : P_SETTLE;
    end else if (ph == P_RUN) begin
      if (!ls || bad) nph = P_RESET;
    end
    if (nph != ph || req) entry = cyc + 1;
    ph = nph;
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      cyc++;
      #1;
      chk("dcm_rst", dcm_rst, ph == P_RESET);
      chk("sys_rst", sys_rst, ph != P_RUN);
      chk("ready", ready, ph == P_RUN);
      chk("fail", fail, failed);
      chk("retry_cnt", retry_cnt, retries[1:0]);
    end
  endtask

  initial begin
    int run_len;
    step(3);
    rst = 0;
    // first lock after release
    step(9);
    dcm_locked = 1;
    step(20);
    chk("locked_run", ready, 1);
    // one-cycle lock dropout while running
    dcm_locked = 0;
    step(1);
    dcm_locked = 1;
    step(1);
    chk("drop_still_run", sys_rst, 0);
    step(1);
    chk("drop_sysrst", sys_rst, 1);
    step(1);
    chk("drop_dcmrst", dcm_rst, 1);
    chk("drop_retry", retry_cnt, 0);
    step(25);
    chk("relocked", ready, 1);
    // never lock: retries exhausted
    dcm_locked = 0;
    step(3 * (RP + LT) + 10);
    chk("fault_fail", fail, 1);
    chk("fault_dcmrst", dcm_rst, 0);
    chk("fault_retry", retry_cnt, MR);
    // software relock out of FAULT
    req = 1;
    step(1);
    req = 0;
    chk("relock_fail_clr", fail, 0);
    chk("relock_retry_clr", retry_cnt, 0);
    dcm_locked = 1;
    step(20);
    chk("relock_run", ready, 1);
    // glitching lock during settle never reaches RUN
    dcm_locked = 0;
    step(6);
    for (int i = 0; i < 18; i++) begin
      dcm_locked = (i % 3 != 2);
      step(1);
      chk("glitch_norun", ready, 0);
    end
    dcm_locked = 1;
    step(12);
    chk("stable_run", ready, 1);
    // CLKFX stopped status while running
    dcm_status = 8'h04;
    step(10);
`ifdef DCM_STATUS_MON_EN
    chk("status_relock", ready, 0);
`else
    chk("status_ignored", ready, 1);
`endif
    dcm_status = 0;
    step(15);
    // asynchronous reset mid-operation
    rst = 1;
    #2;
    chk("async_dcmrst", dcm_rst, 1);
    chk("async_ready", ready, 0);
    step(2);
    rst = 0;
    step(15);
    // randomized lock runs, status, relock requests and resets
    run_len = 0;
    for (int i = 0; i < 600; i++) begin
      if (run_len == 0) begin
        dcm_locked = ($urandom_range(0, 3) != 0);
        run_len = $urandom_range(1, 14);
      end
      run_len--;
      dcm_status = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
      req = ($urandom_range(0, 49) == 0);
      rst = ($urandom_range(0, 99) == 0);
      step(1);
    end
    rst = 0;
    req = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
